// File: rtl/pwm_multichannel.sv
// pwm_multichannel: multi-channel PWM generator with one shared period counter,
// a programmable prescaler and double-buffered period/duty registers.
// Optional feature: define PWM_CENTER_EN for a triangle (centre-aligned) counter;
// without it the counter is a plain sawtooth with no direction state.
module pwm_multichannel #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                      cclk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      load,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      period_start,
    output logic                      pending
);

    logic [PRESCALE_W-1:0]     presc_q, presc_d;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]          per_shadow_q, per_shadow_d;
    logic [CHANNELS*WIDTH-1:0] duty_shadow_q, duty_shadow_d;
    logic [WIDTH-1:0]          per_act_q, per_act_d;
    logic [CHANNELS*WIDTH-1:0] duty_act_q, duty_act_d;
    logic                      pending_q, pending_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      period_start_q, period_start_d;
`ifdef PWM_CENTER_EN
    logic                      dir_up_q, dir_up_d;
`endif

    logic tick;
    logic wrap;
    logic boundary;

    // Prescaler and shared counter: decide the tick, the next count and whether
    // this cycle is a period boundary (wrap back to zero).
    always_comb begin
        tick    = 1'b0;
        wrap    = 1'b0;
        presc_d = presc_q;
        cnt_d   = cnt_q;
`ifdef PWM_CENTER_EN
        dir_up_d = dir_up_q;
`endif
        if (!enable) begin
            presc_d = '0;
        end else if (presc_q >= prescale) begin
            // >= so a prescale lowered below the running value ticks at once
            tick    = 1'b1;
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESCALE_W'(1);
        end

`ifdef PWM_CENTER_EN
        if (!enable) begin
            cnt_d    = '0;
            dir_up_d = 1'b1;
        end else if (tick) begin
            if (dir_up_q && (cnt_q < per_act_q)) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else begin
                // at the top (or period 0) turn around; zero stays zero
                cnt_d    = (cnt_q == '0) ? '0 : cnt_q - WIDTH'(1);
                dir_up_d = 1'b0;
            end
            if (cnt_d == '0) begin
                wrap     = 1'b1;
                dir_up_d = 1'b1;
            end
        end
`else
        if (!enable) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == per_act_q) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
`endif
    end

    // Double buffering: load fills the shadow registers; a wrap (or being
    // disabled) moves new values into the active set, preferring a coincident load.
    always_comb begin
        boundary      = wrap | ~enable;
        per_shadow_d  = per_shadow_q;
        duty_shadow_d = duty_shadow_q;
        per_act_d     = per_act_q;
        duty_act_d    = duty_act_q;
        pending_d     = pending_q;
        if (load) begin
            per_shadow_d  = period;
            duty_shadow_d = duty;
        end
        if (boundary) begin
            if (load) begin
                per_act_d  = period;
                duty_act_d = duty;
            end else if (pending_q) begin
                per_act_d  = per_shadow_q;
                duty_act_d = duty_shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Per-channel duty compare against the current count and period marker.
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable & (cnt_q < duty_act_q[i*WIDTH +: WIDTH]);
        end
        period_start_d = tick & wrap & enable;
    end

    // State registers with synchronous reset.
    always_ff @(posedge cclk) begin
        if (rst) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            per_shadow_q   <= '0;
            duty_shadow_q  <= '0;
            per_act_q      <= '0;
            duty_act_q     <= '0;
            pending_q      <= 1'b0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
`ifdef PWM_CENTER_EN
            dir_up_q       <= 1'b1;
`endif
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            per_shadow_q   <= per_shadow_d;
            duty_shadow_q  <= duty_shadow_d;
            per_act_q      <= per_act_d;
            duty_act_q     <= duty_act_d;
            pending_q      <= pending_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
`ifdef PWM_CENTER_EN
            dir_up_q       <= dir_up_d;
`endif
        end
    end

    assign pwm          = pwm_q;
    assign period_start = period_start_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Testbench for pwm_multichannel: per-cycle comparison against a phase-based
// behavioural model, plus directed scenarios with hand-computed expectations.
// Honours PWM_CENTER_EN the same way as the design.
module tb_pwm_multichannel;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam logic [31:0] DUTY_A = 32'hFF0A_0300;  // ch3=255 ch2=10 ch1=3 ch0=0
    localparam logic [31:0] DUTY_B = 32'hFF0A_0700;  // ch1 raised to 7

    logic          cclk;
    logic          rst;
    logic          enable;
    logic [7:0]    prescale;
    logic [7:0]    period;
    logic [31:0]   duty;
    logic          load;
    logic [CH-1:0] pwm;
    logic          period_start;
    logic          pending;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 0;

    int meas_len;
    int meas_hi[CH];
    int ps_count;
    int hi_count;

    pwm_multichannel #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(8)) dut (
        .cclk(cclk), .rst(rst), .enable(enable), .prescale(prescale),
        .period(period), .duty(duty), .load(load), .pwm(pwm),
        .period_start(period_start), .pending(pending)
    );

    // Free-running clock.
    initial begin
        cclk = 1'b0;
        forever #5 cclk = ~cclk;
    end

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "[TB] timeout");
    end

    // Model state: position inside the period counted in ticks, plus buffers.
    int m_sub;
    int m_phase;
    int m_per_act;
    int m_per_sh;
    int m_duty_act[CH];
    int m_duty_sh[CH];
    bit m_pend;
    logic [CH-1:0] exp_pwm  = '0;
    logic          exp_ps   = 1'b0;
    logic          exp_pend = 1'b0;

    // Number of ticks in one period for a given active period value.
    function automatic int periodTicks(input int per);
`ifdef PWM_CENTER_EN
        return (per == 0) ? 1 : 2 * per;
`else
        return per + 1;
`endif
    endfunction

    // Count value seen at a given tick position inside the period.
    function automatic int countAt(input int phase, input int per);
`ifdef PWM_CENTER_EN
        return (phase <= per) ? phase : 2 * per - phase;
`else
        return phase;
`endif
    endfunction

    // Advance the model by one clock using the inputs seen at this edge.
    always @(posedge cclk) begin : model_step
        bit tck;
        bit wrapped;
        int c;
        if (rst) begin
            m_sub = 0; m_phase = 0; m_per_act = 0; m_per_sh = 0; m_pend = 0;
            for (int i = 0; i < CH; i++) begin
                m_duty_act[i] = 0;
                m_duty_sh[i]  = 0;
            end
            exp_pwm = '0; exp_ps = 1'b0; exp_pend = 1'b0;
        end else begin
            c = countAt(m_phase, m_per_act);
            for (int i = 0; i < CH; i++) exp_pwm[i] = enable && (c < m_duty_act[i]);
            tck     = enable && (m_sub >= int'(prescale));
            wrapped = 0;
            if (!enable) begin
                m_sub = 0;
                m_phase = 0;
            end else begin
                m_sub = tck ? 0 : m_sub + 1;
                if (tck) begin
                    if (m_phase + 1 >= periodTicks(m_per_act)) begin
                        m_phase = 0;
                        wrapped = 1;
                    end else begin
                        m_phase = m_phase + 1;
                    end
                end
            end
            exp_ps = wrapped;
            if (load) begin
                m_per_sh = int'(period);
                for (int i = 0; i < CH; i++) m_duty_sh[i] = int'(duty[i*W +: W]);
            end
            if (!enable || wrapped) begin
                if (load) begin
                    m_per_act = int'(period);
                    for (int i = 0; i < CH; i++) m_duty_act[i] = int'(duty[i*W +: W]);
                end else if (m_pend) begin
                    m_per_act = m_per_sh;
                    for (int i = 0; i < CH; i++) m_duty_act[i] = m_duty_sh[i];
                end
                m_pend = 0;
            end else if (load) begin
                m_pend = 1;
            end
            exp_pend = m_pend;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge cclk) begin
        if (check_en) begin
            checkOutput("model_pwm", 32'(pwm), 32'(exp_pwm));
            checkOutput("model_period_start", 32'(period_start), 32'(exp_ps));
            checkOutput("model_pending", 32'(pending), 32'(exp_pend));
        end
    end

    // Drive one cycle of inputs; load is a single-cycle strobe.
    task automatic applyStimulus(input bit en, input bit ld, input logic [7:0] psc,
                                 input logic [7:0] per, input logic [31:0] dty);
        enable   = en;
        load     = ld;
        prescale = psc;
        period   = per;
        duty     = dty;
        @(negedge cclk);
        load = 1'b0;
    endtask

    // Wait for a period_start, then measure the following full period.
    task automatic measurePeriod();
        int guard = 0;
        do begin
            @(negedge cclk);
            guard++;
        end while (!period_start && guard < 2000);
        if (!period_start) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL measure_timeout: got no period_start, expected one within 2000 cycles");
            meas_len = -1;
            return;
        end
        meas_len = 0;
        for (int i = 0; i < CH; i++) meas_hi[i] = 0;
        do begin
            @(negedge cclk);
            meas_len++;
            for (int i = 0; i < CH; i++) meas_hi[i] += int'(pwm[i]);
        end while (!period_start && meas_len < 2000);
    endtask

    // Directed scenarios.
    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0;
        prescale = '0; period = '0; duty = '0;
        repeat (2) @(negedge cclk);
        checkOutput("reset_pwm", 32'(pwm), 32'd0);
        checkOutput("reset_period_start", 32'(period_start), 32'd0);
        checkOutput("reset_pending", 32'(pending), 32'd0);
        check_en = 1'b1;
        rst = 1'b0;

`ifdef PWM_CENTER_EN
        applyStimulus(0, 1, 8'd0, 8'd4, 32'h0000_0200);
        applyStimulus(0, 0, 8'd0, 8'd4, 32'h0000_0200);
        applyStimulus(1, 0, 8'd0, 8'd4, 32'h0000_0200);
        measurePeriod();
        checkOutput("center_len", meas_len, 8);
        checkOutput("center_ch1_high", meas_hi[1], 3);
        checkOutput("center_ch0_high", meas_hi[0], 0);
`else
        // Basic duty: period 10, ch0 low, ch1 3 of 10, ch2/ch3 always high.
        applyStimulus(0, 1, 8'd0, 8'd9, DUTY_A);
        applyStimulus(0, 0, 8'd0, 8'd9, DUTY_A);
        applyStimulus(1, 0, 8'd0, 8'd9, DUTY_A);
        measurePeriod();
        checkOutput("basic_len", meas_len, 10);
        checkOutput("basic_ch0_high", meas_hi[0], 0);
        checkOutput("basic_ch1_high", meas_hi[1], 3);
        checkOutput("basic_ch2_high", meas_hi[2], 10);
        checkOutput("basic_ch3_high", meas_hi[3], 10);

        // Buffered update mid-period: pending until the boundary, then 7 high.
        repeat (4) applyStimulus(1, 0, 8'd0, 8'd9, DUTY_A);
        applyStimulus(1, 1, 8'd0, 8'd9, DUTY_B);
        checkOutput("buffered_pending", 32'(pending), 32'd1);
        measurePeriod();
        checkOutput("buffered_len", meas_len, 10);
        checkOutput("buffered_ch1_high", meas_hi[1], 7);

        // Prescale 2: period 30 cycles, ch1 duty 3 -> 9 cycles high.
        applyStimulus(1, 1, 8'd2, 8'd9, DUTY_A);
        measurePeriod();
        measurePeriod();
        checkOutput("prescale_len", meas_len, 30);
        checkOutput("prescale_ch1_high", meas_hi[1], 9);
        checkOutput("prescale_ch0_high", meas_hi[0], 0);
        checkOutput("prescale_ch3_high", meas_hi[3], 30);

        // Load on the wrap edge: period 4 applies at once, pending never rises.
        applyStimulus(1, 0, 8'd0, 8'd9, DUTY_A);
        repeat (8) applyStimulus(1, 0, 8'd0, 8'd9, DUTY_A);
        applyStimulus(1, 1, 8'd0, 8'd4, DUTY_A);
        checkOutput("coincident_pending", 32'(pending), 32'd0);
        checkOutput("coincident_period_start", 32'(period_start), 32'd1);
        measurePeriod();
        checkOutput("coincident_len", meas_len, 5);
        checkOutput("coincident_ch1_high", meas_hi[1], 3);
        checkOutput("coincident_ch2_high", meas_hi[2], 5);

        // Reset mid-period with output high and a pending load.
        applyStimulus(1, 0, 8'd0, 8'd4, DUTY_A);
        applyStimulus(1, 1, 8'd0, 8'd9, DUTY_A);
        checkOutput("prereset_pending", 32'(pending), 32'd1);
        checkOutput("prereset_ch2", 32'(pwm[2]), 32'd1);
        rst = 1'b1;
        @(negedge cclk);
        checkOutput("midreset_pwm", 32'(pwm), 32'd0);
        checkOutput("midreset_pending", 32'(pending), 32'd0);
        checkOutput("midreset_period_start", 32'(period_start), 32'd0);
        rst = 1'b0;
        hi_count = 0;
        ps_count = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge cclk);
            hi_count += int'(pwm != '0);
            ps_count += int'(period_start);
        end
        checkOutput("postreset_pwm_high_cycles", hi_count, 0);
        checkOutput("postreset_period_starts", ps_count, 20);

        // Disabled: output forced low, loaded values used by first enabled period.
        applyStimulus(0, 0, 8'd0, 8'd9, DUTY_A);
        checkOutput("disabled_pwm", 32'(pwm), 32'd0);
        applyStimulus(0, 1, 8'd0, 8'd9, DUTY_A);
        applyStimulus(0, 0, 8'd0, 8'd9, DUTY_A);
        applyStimulus(1, 0, 8'd0, 8'd9, DUTY_A);
        measurePeriod();
        checkOutput("reenable_len", meas_len, 10);
        checkOutput("reenable_ch1_high", meas_hi[1], 3);
`endif

        repeat (3) @(negedge cclk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised multi-channel PWM generator: one shared period counter with a programmable prescaler drives CHANNELS independent duty comparators. Period and duty values are double-buffered and take effect only at a period boundary, so updates are glitch-free. The block replaces single-channel pulse-train PWM generation for motor and LED drive paths and feeds pad outputs directly.

## Interface
- WIDTH, 8: counter, period and per-channel duty width.
- CHANNELS, 4: number of PWM outputs.
- PRESCALE_W, 8: prescaler setting width.
- cclk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous and active-high.
- enable  input  1  run when high; hold counter at 0 when low.
- prescale  input  PRESCALE_W  a counter tick occurs every prescale+1 cycles; sampled live.
- period  input  WIDTH  terminal count; captured on load.
- duty  input  CHANNELS*WIDTH  channel i duty in bits [i*WIDTH +: WIDTH]; captured on load.
- load  input  1  one-cycle strobe; captures period and duty into shadow registers.
- pwm  output  CHANNELS  registered PWM outputs.
- period_start  output  1  registered one-cycle pulse as the counter returns to 0.
- pending  output  1  shadow values are waiting to be applied.

## Operation
- Reset: pwm=0, period_start=0, pending=0; prescaler, counter, shadow and active registers all cleared (active period=0, duty=0). Reset overrides every other input on the same edge.
- Prescaler: counts 0..prescale; tick asserts in the cycle its value equals prescale, then it returns to 0. prescale=0 gives a tick every cycle.
- Counter (sawtooth): on tick, if cnt==period_act then cnt<=0 (wrap), else cnt<=cnt+1. period_act=0 gives a wrap on every tick.
- Compare: pwm[i] <= enable & (cnt < duty_act[i]), evaluated every cycle. duty=0 gives a constant low output. duty>period gives a constant high output.
- Load: load=1 writes the inputs into the shadow registers and sets pending. A second load before the next wrap overwrites the shadow registers.
- Apply: at a wrap, if pending=1 or load=1, the active registers take the new values and pending clears. When load coincides with a wrap, this cycle's inputs are applied directly.
- Disabled (enable=0): the prescaler and counter are held at 0 and pwm=0. Pending shadow values are applied immediately, so the first period after enable uses them.
- period_start <= tick & wrap & enable.

## Timing
- Counter-to-output latency is 1 cycle: pwm reflects the counter value of the previous cycle.
- With the counter already at 0, enable rising at edge N gives the first tick at edge N+prescale+1. pwm is high from edge N+1 when duty_act>0.
- Period length is (period_act+1)*(prescale+1) cycles. High time is min(duty_act, period_act+1)*(prescale+1) cycles.
- New values take effect in the output starting with the first cycle after the period_start pulse.
- A prescale change mid-count takes effect on the next prescaler compare. There is no buffering for prescale.

## Configuration
- PWM_CENTER_EN defined: the counter runs as a triangle. It counts up 0..period_act, then down period_act-1..1, then back to 0.
  - The counter reaching 0 is the wrap/apply/period_start point.
  - Period length is 2*period_act ticks, with a minimum of 1 tick when period_act=0.
  - Pulses are centred on count 0.
- PWM_CENTER_EN undefined: sawtooth counter only. There is no direction state.

## Test plan
- Basic duty: WIDTH=8, prescale=0, period=9, duty={255,10,3,0} (ch3..ch0), load, then enable.
  - period_start every 10 cycles.
  - ch0 constantly low; ch1 high 3 of 10 cycles; ch2 and ch3 constantly high.
- Buffered update: load ch1 duty 3→7 mid-period.
  - pending=1 and the waveform is unchanged until period_start.
  - The next period has ch1 high 7 cycles; no runt pulse.
- Prescale: prescale=2, period=9, duty ch1=3 → period 30 cycles; ch1 high 9 cycles.
- Load coincident with wrap: the new period=4 applies in the very next period (5 cycles); pending stays 0.
- Reset mid-period: rst high for 1 cycle with pwm high → pwm=0, pending=0, counter=0 on the next edge. After release with enable=1 and no load, pwm stays 0.
- PWM_CENTER_EN: prescale=0, period=4, duty=2 → count sequence 0,1,2,3,4,3,2,1 repeating every 8 cycles. pwm is high for counts 0, 1, 1 (3 of 8 cycles), centred on the period_start.
